// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, FSM encoding and instruction field layout
package pipe_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;
  localparam int OP_HI = 31;
  localparam int OP_LO = 15;
  localparam int RS_HI = 14;
  localparam int RS_LO = 10;
  localparam int RT_HI = 9;
  localparam int RT_LO = 5;
  localparam int RD_HI = 4;
  localparam int RD_LO = 0;
  localparam int IFSTOP_BIT = 2;
  function automatic logic [OP_HI-OP_LO:0] opcode(input logic [31:0] i);
    return i[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory port bundle between the fetch logic and its memory
interface if_stage_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic we;
  modport master(output raddr, waddr, wdata, we, input rdata);
  modport slave(input raddr, waddr, wdata, we, output rdata);
endinterface

// File: rtl/instr_mem.sv
// instr_mem: 2**ADDR_W x 32 instruction store, async read, sync write, never reset
module instr_mem #(parameter int ADDR_W = 8) (
  input logic clk,
  if_stage_if.slave bus
);
  logic [31:0] mem [2**ADDR_W];
  assign bus.rdata = mem[bus.raddr];
  always_ff @(posedge clk)
    if (bus.we) mem[bus.waddr] <= bus.wdata;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IDLE/FETCH/HALT control, PC and IF/ID register
module if_stage #(
  parameter int ADDR_W = 8,
  parameter logic [31:0] NOP = pipe_pkg::NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              ifstop_in,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid,
  output logic              halted
);
  import pipe_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_out_n;
  logic [31:0] instr_n;
  logic valid_n;
  if_stage_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.raddr = pc;
  assign bus.we = imem_we;
  assign bus.waddr = imem_addr;
  assign bus.wdata = imem_wdata;
  instr_mem #(.ADDR_W(ADDR_W)) u_mem (.clk(clk), .bus(bus));
  // halt beats redirect beats stall; a bubble (valid=0) can never halt
  always_comb begin
    state_n = state;
    pc_n = pc;
    pc_out_n = pc_out;
    instr_n = NOP;
    valid_n = 1'b0;
    if (state == FETCH) begin
      if (ifstop_in && valid) state_n = HALT;
      else if (redirect) pc_n = redirect_pc;
      else if (stall) begin
        instr_n = instr;
        valid_n = valid;
      end else begin
        instr_n = bus.rdata;
        pc_out_n = pc;
        valid_n = 1'b1;
        pc_n = pc + 1'b1;
      end
    end else if (start) begin
      state_n = FETCH;
      pc_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      pc_out <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pc_out <= pc_out_n;
      instr <= instr_n;
      valid <= valid_n;
    end
  assign halted = state == HALT;
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the PC width in words (imem depth 2**ADDR_W).
REQ-002 SHALL have parameter NOP, default 32'h0000_0000, meaning the bubble instruction inserted on squash.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit; a one-cycle pulse that begins fetch from PC 0.
REQ-006 SHALL have port stall, input, 1 bit; holds the PC and the IF/ID register.
REQ-007 SHALL have port ifstop_in, input, 1 bit; the decode halt flag, control[2] of the decode stage.
REQ-008 SHALL have port redirect, input, 1 bit; loads redirect_pc and flushes IF/ID.
REQ-009 SHALL have port redirect_pc, input, ADDR_W bits; the redirect target word address.
REQ-010 SHALL have port imem_we, input, 1 bit; the instruction-memory load write enable.
REQ-011 SHALL have port imem_addr, input, ADDR_W bits; the load address.
REQ-012 SHALL have port imem_wdata, input, 32 bits; the load data.
REQ-013 SHALL have port instr, output, 32 bits; the IF/ID instruction: opcode [31:15], rs [14:10], rt [9:5], rd [4:0].
REQ-014 SHALL have port pc_out, output, ADDR_W bits; the PC of the instruction in instr.
REQ-015 SHALL have port valid, output, 1 bit; instr holds a real (non-bubble) instruction.
REQ-016 SHALL have port halted, output, 1 bit; high while the FSM is in HALT.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH and HALT.
REQ-018 SHALL move IDLE->FETCH on start; HALT->FETCH on start with PC reloaded to 0; FETCH->HALT on ifstop_in && valid; and otherwise hold state.
REQ-019 SHALL apply per-edge priority in FETCH of ifstop_in > redirect > stall > normal advance.
REQ-020 SHALL, on normal advance, latch instr<=imem[PC], pc_out<=PC, valid<=1 and set PC<=PC+1, wrapping from 2**ADDR_W-1 to 0.
REQ-021 SHALL give fetch latency of one cycle: PC=0 is presented in the first FETCH cycle and instr=imem[0] with valid=1 appears on the following edge.
REQ-022 SHALL, on stall, hold PC, instr, pc_out and valid unchanged.
REQ-023 SHALL, on redirect (including during stall), set PC<=redirect_pc, instr<=NOP and valid<=0; the target instruction appears one cycle later.
REQ-024 SHALL, on ifstop_in && valid, set instr<=NOP and valid<=0, freeze PC, enter HALT and ignore stall and redirect on that edge.
REQ-025 SHALL ignore ifstop_in when valid=0.
REQ-026 SHALL, in IDLE and HALT, hold instr=NOP and valid=0 and freeze PC.
REQ-027 SHALL use an asynchronous imem read addressed by PC, with writes on the clock edge when imem_we=1.
REQ-028 SHALL, when a write and a fetch target the same address on one edge, latch the old data into instr.
REQ-029 SHALL accept imem writes in every state.
REQ-030 SHALL drive halted = (state==HALT) combinationally.
REQ-031 SHALL, when start arrives in FETCH, ignore it.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-fetch, immediately set state=IDLE, PC=0, instr=NOP, pc_out=0, valid=0 and halted=0.
REQ-033 SHALL NOT clear imem contents on reset.
REQ-034 SHALL resume normal operation on the first rising edge after rst is released.

Structure
REQ-035 SHALL place NOP, the state encoding, the opcode/rs/rt/rd field bit positions and the ifstop control-bit index (2) in shared package pipe_pkg.
REQ-036 SHALL implement instruction memory as sub-module instr_mem (2**ADDR_W x 32, async read, sync write).
REQ-037 SHALL contain the FSM, PC and IF/ID register in if_stage.

Verification
REQ-038 SHALL cover load imem[0..3]=A0,A1,A2,A3 then pulse start -> instr=A0,A1,A2,A3 on consecutive cycles with pc_out 0..3 and valid=1.
REQ-039 SHALL cover stall high for 3 cycles with instr=A1 -> instr, pc_out and valid are unchanged for 3 cycles and A2 follows after release.
REQ-040 SHALL cover redirect with redirect_pc=8 while instr=A1 -> next cycle instr=NOP with valid=0, then instr=imem[8] with pc_out=8.
REQ-041 SHALL cover ifstop_in=1 with stall=1 and redirect=1 on the same cycle -> HALT entered, halted=1, valid=0 and PC frozen; a subsequent start refetches from PC 0.
REQ-042 SHALL cover a fetch run from PC 254 (ADDR_W=8) -> pc_out 254, 255, 0, 1; and imem write to the fetched address on the same edge -> old data latched.
REQ-043 SHALL cover rst asserted mid-FETCH between clock edges -> outputs reach reset values without a clock edge and imem contents survive.
